branch_predictor: RTL and testbench

- Prediction source and resolution sink for the IF→ID→EX pipeline.
- IF queries it each cycle with the fetch PC and receives the predicted-taken bit and next PC. The pipeline carries these down to ID/EX as predict_result / npc.
- When the branch or jump reaches EX, this block compares the actual outcome against the carried npc. It raises branch_error (which flushes the IF/ID and ID/EX registers) and trains a direct-mapped BHT/BTB.

---
 rtl/branch_predictor.sv | 131 +++++++++++++
 tb/tb_branch_predictor.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped BHT/BTB branch predictor: zero-latency fetch lookup, EX-stage
// misprediction detection with redirect, and a single training write per resolved branch.
`ifndef StallBus
`define StallBus 1:0
`endif
`ifndef Pass
`define Pass 2'b00
`endif
`ifndef Hold
`define Hold 2'b01
`endif
`ifndef Bubb
`define Bubb 2'b10
`endif

module branch_predictor #(
    parameter int ADDR_W     = 32,
    parameter int INDEX_BITS = 6,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] if_pc_i,
    output logic              predict_result_o,
    output logic [ADDR_W-1:0] npc_o,
    input  logic [`StallBus]  stall_ex_i,
    input  logic              ex_valid_i,
    input  logic              ex_jump_i,
    input  logic [ADDR_W-1:0] ex_pc_i,
    input  logic              ex_taken_i,
    input  logic [ADDR_W-1:0] ex_target_i,
    input  logic [ADDR_W-1:0] ex_npc_i,
    output logic              branch_error_o,
    output logic [ADDR_W-1:0] redirect_pc_o,
    output logic [CNT_W-1:0]  branch_cnt_o,
    output logic [CNT_W-1:0]  miss_cnt_o
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = ADDR_W - INDEX_BITS - 2;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [ADDR_W-1:0] target;
        logic             jump;
        logic [1:0]       cnt;
    } entry_t;

    localparam entry_t ENTRY_RST = '{valid: 1'b0, tag: '0, target: '0, jump: 1'b0, cnt: 2'b01};

    entry_t table_q [ENTRIES];

    logic [INDEX_BITS-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0]      if_tag, ex_tag;
    entry_t                if_entry, ex_entry, upd_entry;
    logic                  if_hit, ex_hit;
    logic                  taken;
    logic [ADDR_W-1:0]     actual;
    logic                  fire;
    logic                  upd_en;
    logic                  unused_pc_bits;

    // Word-aligned PCs: the two low bits never reach the index or tag.
    assign unused_pc_bits = ^{if_pc_i[1:0], ex_pc_i[1:0]};

    assign if_idx   = if_pc_i[INDEX_BITS+1:2];
    assign if_tag   = if_pc_i[ADDR_W-1:INDEX_BITS+2];
    assign if_entry = table_q[if_idx];
    assign if_hit   = if_entry.valid && (if_entry.tag == if_tag);

    // Lookup reads the registered table only, so a same-cycle update is not bypassed.
    assign predict_result_o = !rst && if_hit && (if_entry.jump || if_entry.cnt[1]);
    assign npc_o            = predict_result_o ? if_entry.target : if_pc_i + ADDR_W'(4);

    assign ex_idx   = ex_pc_i[INDEX_BITS+1:2];
    assign ex_tag   = ex_pc_i[ADDR_W-1:INDEX_BITS+2];
    assign ex_entry = table_q[ex_idx];
    assign ex_hit   = ex_entry.valid && (ex_entry.tag == ex_tag);

    assign taken          = ex_jump_i | ex_taken_i;
    assign actual         = taken ? ex_target_i : ex_pc_i + ADDR_W'(4);
    assign redirect_pc_o  = actual;
    // Flush outranks hold in ID/EX, so the error is raised regardless of the stall code.
    assign branch_error_o = ex_valid_i && !rst && (actual != ex_npc_i);
    assign fire           = ex_valid_i && (stall_ex_i == `Pass) && !rst;

    always_comb begin
        // NOTE: defaults first so every path assigns upd_entry/upd_en and no latch is inferred.
        upd_entry = ex_entry;
        upd_en    = 1'b0;
        if (ex_hit) begin
            upd_en = 1'b1;
            if (taken) begin
                upd_entry.cnt    = (ex_entry.cnt == 2'b11) ? 2'b11 : ex_entry.cnt + 2'b01;
                upd_entry.target = ex_target_i;
                upd_entry.jump   = ex_jump_i;
            end else begin
                upd_entry.cnt = (ex_entry.cnt == 2'b00) ? 2'b00 : ex_entry.cnt - 2'b01;
            end
        end else if (taken) begin
            upd_en           = 1'b1;
            upd_entry.valid  = 1'b1;
            upd_entry.tag    = ex_tag;
            upd_entry.target = ex_target_i;
            upd_entry.jump   = ex_jump_i;
            upd_entry.cnt    = ex_jump_i ? 2'b11 : 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the table is cleared on reset because a stale valid bit would steer fetch;
            // state uses non-blocking assignments so all entries update together at the edge.
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= ENTRY_RST;
            end
            branch_cnt_o <= '0;
            miss_cnt_o   <= '0;
        end else if (fire) begin
            if (upd_en) begin
                table_q[ex_idx] <= upd_entry;
            end
            branch_cnt_o <= branch_cnt_o + CNT_W'(1);
            if (branch_error_o) begin
                miss_cnt_o <= miss_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor: lookup, resolution,
// training, stall handling, aliasing and reset-during-fire.
`ifndef StallBus
`define StallBus 1:0
`endif
`ifndef Pass
`define Pass 2'b00
`endif
`ifndef Hold
`define Hold 2'b01
`endif
`ifndef Bubb
`define Bubb 2'b10
`endif

module tb_branch_predictor;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       if_pc_i;
    logic              predict_result_o;
    logic [31:0]       npc_o;
    logic [`StallBus]  stall_ex_i;
    logic              ex_valid_i;
    logic              ex_jump_i;
    logic [31:0]       ex_pc_i;
    logic              ex_taken_i;
    logic [31:0]       ex_target_i;
    logic [31:0]       ex_npc_i;
    logic              branch_error_o;
    logic [31:0]       redirect_pc_o;
    logic [31:0]       branch_cnt_o;
    logic [31:0]       miss_cnt_o;

    int tests_run = 0;
    int tests_failed = 0;

    branch_predictor #(.ADDR_W(32), .INDEX_BITS(6), .CNT_W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .if_pc_i          (if_pc_i),
        .predict_result_o (predict_result_o),
        .npc_o            (npc_o),
        .stall_ex_i       (stall_ex_i),
        .ex_valid_i       (ex_valid_i),
        .ex_jump_i        (ex_jump_i),
        .ex_pc_i          (ex_pc_i),
        .ex_taken_i       (ex_taken_i),
        .ex_target_i      (ex_target_i),
        .ex_npc_i         (ex_npc_i),
        .branch_error_o   (branch_error_o),
        .redirect_pc_o    (redirect_pc_o),
        .branch_cnt_o     (branch_cnt_o),
        .miss_cnt_o       (miss_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a posedge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resolve(input logic jump, input logic [31:0] pc, input logic tk,
                           input logic [31:0] tgt, input logic [31:0] npc,
                           input logic [`StallBus] stall);
        ex_valid_i  = 1'b1;
        ex_jump_i   = jump;
        ex_pc_i     = pc;
        ex_taken_i  = tk;
        ex_target_i = tgt;
        ex_npc_i    = npc;
        stall_ex_i  = stall;
        #1;
    endtask

    task automatic idle();
        ex_valid_i = 1'b0;
        stall_ex_i = `Pass;
    endtask

    task automatic query(input string tag, input logic [31:0] pc, input logic pred,
                         input logic [31:0] npc);
        if_pc_i = pc;
        #1;
        check({tag, ".pred"}, {31'b0, predict_result_o}, {31'b0, pred});
        check({tag, ".npc"}, npc_o, npc);
    endtask

    initial begin
        rst = 1'b1; if_pc_i = 32'h1000;
        ex_valid_i = 1'b0; ex_jump_i = 1'b0; ex_pc_i = '0; ex_taken_i = 1'b0;
        ex_target_i = '0; ex_npc_i = '0; stall_ex_i = `Pass;
        tick(); tick();
        rst = 1'b0;

        // Reset state.
        query("rst_lookup", 32'h1000, 1'b0, 32'h1004);
        check("rst_bcnt", branch_cnt_o, 32'd0);
        check("rst_mcnt", miss_cnt_o, 32'd0);

        // First taken resolution allocates; same-cycle lookup still sees the old table.
        if_pc_i = 32'h1000;
        resolve(1'b0, 32'h1000, 1'b1, 32'h2000, 32'h1004, `Pass);
        check("alloc_err", {31'b0, branch_error_o}, 32'd1);
        check("alloc_redir", redirect_pc_o, 32'h2000);
        check("same_cycle_npc", npc_o, 32'h1004);
        tick(); idle();
        query("after_alloc", 32'h1000, 1'b1, 32'h2000);
        check("alloc_bcnt", branch_cnt_o, 32'd1);
        check("alloc_mcnt", miss_cnt_o, 32'd1);

        // Not taken: cnt 10 -> 01, prediction flips to fall-through.
        resolve(1'b0, 32'h1000, 1'b0, 32'h2000, 32'h2000, `Pass);
        check("nt1_err", {31'b0, branch_error_o}, 32'd1);
        check("nt1_redir", redirect_pc_o, 32'h1004);
        tick(); idle();
        query("after_nt1", 32'h1000, 1'b0, 32'h1004);

        // Not taken again (correctly predicted): cnt 01 -> 00.
        resolve(1'b0, 32'h1000, 1'b0, 32'h2000, 32'h1004, `Pass);
        check("nt2_err", {31'b0, branch_error_o}, 32'd0);
        tick();
        // Third not taken must saturate at 00.
        check("nt3_err", {31'b0, branch_error_o}, 32'd0);
        tick();
        // One taken from 00 lands at 01 (still predicts not taken); a wrapped counter would predict taken.
        resolve(1'b0, 32'h1000, 1'b1, 32'h2000, 32'h1004, `Pass);
        check("sat_taken_err", {31'b0, branch_error_o}, 32'd1);
        tick(); idle();
        query("sat_lookup", 32'h1000, 1'b0, 32'h1004);
        check("sat_bcnt", branch_cnt_o, 32'd5);
        check("sat_mcnt", miss_cnt_o, 32'd3);

        // jal held by a bubble and three holds: error throughout, trained once on Pass.
        resolve(1'b1, 32'h3000, 1'b0, 32'h3400, 32'h3004, `Bubb);
        check("jal_bubb_err", {31'b0, branch_error_o}, 32'd1);
        tick();
        check("jal_bubb_bcnt", branch_cnt_o, 32'd5);
        for (int i = 0; i < 3; i++) begin
            resolve(1'b1, 32'h3000, 1'b0, 32'h3400, 32'h3004, `Hold);
            check("jal_hold_err", {31'b0, branch_error_o}, 32'd1);
            check("jal_hold_redir", redirect_pc_o, 32'h3400);
            tick();
            check("jal_hold_bcnt", branch_cnt_o, 32'd5);
        end
        query("jal_untrained", 32'h3000, 1'b0, 32'h3004);
        resolve(1'b1, 32'h3000, 1'b0, 32'h3400, 32'h3004, `Pass);
        check("jal_pass_err", {31'b0, branch_error_o}, 32'd1);
        tick(); idle();
        check("jal_bcnt", branch_cnt_o, 32'd6);
        check("jal_mcnt", miss_cnt_o, 32'd4);
        query("jal_lookup", 32'h3000, 1'b1, 32'h3400);

        // Push 0x1000 to cnt 10 so it predicts taken, then evict it with an alias.
        resolve(1'b0, 32'h1000, 1'b1, 32'h2000, 32'h1004, `Pass);
        tick(); idle();
        query("pre_alias", 32'h1000, 1'b1, 32'h2000);
        resolve(1'b0, 32'h1100, 1'b1, 32'h5000, 32'h1104, `Pass);
        check("alias_err", {31'b0, branch_error_o}, 32'd1);
        tick(); idle();
        query("alias_old", 32'h1000, 1'b0, 32'h1004);
        query("alias_new", 32'h1100, 1'b1, 32'h5000);
        check("alias_bcnt", branch_cnt_o, 32'd8);
        check("alias_mcnt", miss_cnt_o, 32'd6);

        // Reset coinciding with a fire: no error, no update, table cleared.
        rst = 1'b1;
        if_pc_i = 32'h1100;
        resolve(1'b0, 32'h1100, 1'b1, 32'h6000, 32'h1104, `Pass);
        check("rstfire_err", {31'b0, branch_error_o}, 32'd0);
        check("rstfire_pred", {31'b0, predict_result_o}, 32'd0);
        check("rstfire_npc", npc_o, 32'h1104);
        tick();
        rst = 1'b0; idle();
        query("rstfire_lookup", 32'h1100, 1'b0, 32'h1104);
        query("rstfire_jal", 32'h3000, 1'b0, 32'h3004);
        check("rstfire_bcnt", branch_cnt_o, 32'd0);
        check("rstfire_mcnt", miss_cnt_o, 32'd0);

        // Fall-through wraps modulo 2^32.
        query("npc_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

        // Correctly predicted jump: counted, not a miss.
        resolve(1'b1, 32'h3000, 1'b0, 32'h3400, 32'h3400, `Pass);
        check("ok_jal_err", {31'b0, branch_error_o}, 32'd0);
        tick(); idle();
        check("ok_jal_bcnt", branch_cnt_o, 32'd1);
        check("ok_jal_mcnt", miss_cnt_o, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
